// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: FSM state encoding and the
// default widths used by fetch_unit and pc_next_logic.
package fetch_unit_pkg;

  localparam int PC_W_DEF   = 8;   // program counter / ROM address width
  localparam int INST_W_DEF = 9;   // instruction word width
  localparam int CNT_W_DEF  = 16;  // retired-instruction counter width

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_pc_next_logic.sv
// pc_next_logic: combinational next-PC selection for the fetch unit.
// Ports:
//   pc           current fetch address
//   load         take start_addr (Start accepted in IDLE or HALTED)
//   run          FSM is in RUN; redirects and increments only apply here
//   halt_req     stop fetching; PC holds
//   stall        hold the PC
//   jump/target  absolute redirect
//   branch_taken/offset  PC-relative redirect, two's-complement offset
//   pc_next      address to register on the next rising edge
module pc_next_logic
  import fetch_unit_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0] pc,
  input  logic            load,
  input  logic [PC_W-1:0] start_addr,
  input  logic            run,
  input  logic            halt_req,
  input  logic            stall,
  input  logic            jump,
  input  logic [PC_W-1:0] target,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] offset,
  output logic [PC_W-1:0] pc_next
);

  // NOTE: pc_next gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_next = pc;
    if (load) begin
      pc_next = start_addr;
    end else if (run) begin
      // Halt outranks stall, which outranks both redirects; sums are kept
      // at PC_W bits so the address wraps modulo 2^PC_W.
      if (halt_req || stall) pc_next = pc;
      else if (jump)         pc_next = target;
      else if (branch_taken) pc_next = pc + offset;
      else                   pc_next = pc + PC_W'(1);
    end
  end

endmodule : pc_next_logic

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer with an IDLE/RUN/HALTED FSM.
// Ports:
//   CLK, Reset         clock and synchronous active-high reset
//   Start, StartAddr   begin execution at StartAddr (IDLE or HALTED only)
//   Stall              hold PC and retire count this cycle
//   Jump, Target       absolute redirect
//   BranchTaken, Offset  relative redirect
//   HaltReq            retire the current instruction, then halt
//   Instruction        combinational ROM data at PC
//   PC                 registered fetch address (ROM address)
//   InstOut            Instruction when InstValid, else zero
//   InstValid          high while in RUN
//   Done               high while in HALTED
//   RetCount           instructions retired since the last Start (saturating)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int INST_W = INST_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Start,
  input  logic [PC_W-1:0]   StartAddr,
  input  logic              Stall,
  input  logic              Jump,
  input  logic [PC_W-1:0]   Target,
  input  logic              BranchTaken,
  input  logic [PC_W-1:0]   Offset,
  input  logic              HaltReq,
  input  logic [INST_W-1:0] Instruction,
  output logic [PC_W-1:0]   PC,
  output logic [INST_W-1:0] InstOut,
  output logic              InstValid,
  output logic              Done,
  output logic [CNT_W-1:0]  RetCount
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_next;
  logic [CNT_W-1:0] ret_count;
  logic            load;
  logic            run;

  assign run  = (state == RUN);
  assign load = Start && (state != RUN);

  pc_next_logic #(.PC_W(PC_W)) u_pc_next (
    .pc           (pc_q),
    .load         (load),
    .start_addr   (StartAddr),
    .run          (run),
    .halt_req     (HaltReq),
    .stall        (Stall),
    .jump         (Jump),
    .target       (Target),
    .branch_taken (BranchTaken),
    .offset       (Offset),
    .pc_next      (pc_next)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= IDLE;
      pc_q      <= '0;
      ret_count <= '0;
    end else begin
      pc_q <= pc_next;
      case (state)
        IDLE, HALTED: begin
          if (Start) begin
            state     <= RUN;
            ret_count <= '0;
          end
        end
        RUN: begin
          if (HaltReq) state <= HALTED;
          // The halting instruction retires even if Stall is also high.
          if ((HaltReq || !Stall) && (ret_count != '1))
            ret_count <= ret_count + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode directly from registered state, so they change only on
  // clock edges; InstOut is the sole combinational path (from Instruction).
  assign PC        = pc_q;
  assign RetCount  = ret_count;
  assign InstValid = run;
  assign Done      = (state == HALTED);
  assign InstOut   = run ? Instruction : '0;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit. The ROM is modelled as
// Instruction = {1'b1, PC ^ 8'hA5}, so InstOut is checkable against PC.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, start, stall, jump, branch_taken, halt_req;
  logic [7:0]  start_addr, target, offset;
  logic [8:0]  instruction;
  logic [7:0]  pc;
  logic [8:0]  inst_out;
  logic        inst_valid, done;
  logic [15:0] ret_count;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign instruction = {1'b1, pc ^ 8'hA5};

  fetch_unit dut (
    .CLK         (clk),
    .Reset       (reset),
    .Start       (start),
    .StartAddr   (start_addr),
    .Stall       (stall),
    .Jump        (jump),
    .Target      (target),
    .BranchTaken (branch_taken),
    .Offset      (offset),
    .HaltReq     (halt_req),
    .Instruction (instruction),
    .PC          (pc),
    .InstOut     (inst_out),
    .InstValid   (inst_valid),
    .Done        (done),
    .RetCount    (ret_count)
  );

  // Observed outputs packed as {PC, RetCount, InstValid, Done, InstOut}.
  logic [34:0] snap;
  assign snap = {pc, ret_count, inst_valid, done, inst_out};

  function automatic logic [34:0] expect_snap(input logic [7:0] e_pc,
      input logic [15:0] e_cnt, input logic e_valid, input logic e_done);
    logic [8:0] e_inst;
    e_inst = e_valid ? {1'b1, e_pc ^ 8'hA5} : 9'h000;
    return {e_pc, e_cnt, e_valid, e_done, e_inst};
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 0; start = 0; stall = 0; jump = 0; branch_taken = 0; halt_req = 0;
    start_addr = 8'h00; target = 8'h00; offset = 8'h00;
  endtask

  task automatic test_reset();
    logic [34:0] e;
    clear_inputs();
    reset = 1;
    step();
    step();
    e = expect_snap(8'h00, 16'd0, 1'b0, 1'b0);
    vectors++;
    if (snap !== e) begin miscompares++; $display("FAIL reset got %h exp %h", snap, e); end
    reset = 0;
  endtask

  task automatic test_sequential();
    logic [34:0] e;
    start = 1; start_addr = 8'h10;
    step();
    clear_inputs();
    e = expect_snap(8'h10, 16'd0, 1'b1, 1'b0);
    vectors++;
    if (snap !== e) begin miscompares++; $display("FAIL seq_start got %h exp %h", snap, e); end
    for (int i = 1; i <= 3; i++) begin
      step();
      e = expect_snap(8'h10 + 8'(i), 16'(i), 1'b1, 1'b0);
      vectors++;
      if (snap !== e) begin miscompares++; $display("FAIL seq_%0d got %h exp %h", i, snap, e); end
    end
  endtask

  // RetCount continues from 3.
  task automatic test_branch_wrap();
    logic [34:0] e;
    jump = 1; target = 8'h05;
    step();
    clear_inputs();
    e = expect_snap(8'h05, 16'd4, 1'b1, 1'b0);
    vectors++;
    if (snap !== e) begin miscompares++; $display("FAIL jump_05 got %h exp %h", snap, e); end

    branch_taken = 1; offset = 8'hFE;
    step();
    clear_inputs();
    e = expect_snap(8'h03, 16'd5, 1'b1, 1'b0);
    vectors++;
    if (snap !== e) begin miscompares++; $display("FAIL branch_neg got %h exp %h", snap, e); end

    jump = 1; target = 8'hFF;
    step();
    clear_inputs();
    e = expect_snap(8'hFF, 16'd6, 1'b1, 1'b0);
    vectors++;
    if (snap !== e) begin miscompares++; $display("FAIL jump_ff got %h exp %h", snap, e); end

    step();
    e = expect_snap(8'h00, 16'd7, 1'b1, 1'b0);
    vectors++;
    if (snap !== e) begin miscompares++; $display("FAIL pc_wrap got %h exp %h", snap, e); end

    // Start while running must be ignored: plain increment, count continues.
    start = 1; start_addr = 8'h80;
    step();
    clear_inputs();
    e = expect_snap(8'h01, 16'd8, 1'b1, 1'b0);
    vectors++;
    if (snap !== e) begin miscompares++; $display("FAIL start_in_run got %h exp %h", snap, e); end
  endtask

  task automatic test_priority();
    logic [34:0] e;
    jump = 1; branch_taken = 1; target = 8'h40; offset = 8'h10;
    step();
    clear_inputs();
    e = expect_snap(8'h40, 16'd9, 1'b1, 1'b0);
    vectors++;
    if (snap !== e) begin miscompares++; $display("FAIL jump_over_branch got %h exp %h", snap, e); end

    stall = 1; jump = 1; target = 8'h99;
    step();
    e = expect_snap(8'h40, 16'd9, 1'b1, 1'b0);
    vectors++;
    if (snap !== e) begin miscompares++; $display("FAIL stall_over_jump got %h exp %h", snap, e); end
    step();
    vectors++;
    if (snap !== e) begin miscompares++; $display("FAIL stall_hold2 got %h exp %h", snap, e); end
    clear_inputs();
  endtask

  task automatic test_halt();
    logic [34:0] e;
    jump = 1; target = 8'h22;
    step();
    clear_inputs();
    e = expect_snap(8'h22, 16'd10, 1'b1, 1'b0);
    vectors++;
    if (snap !== e) begin miscompares++; $display("FAIL jump_22 got %h exp %h", snap, e); end

    // Halt plus stall in the same cycle: halt wins and still retires.
    halt_req = 1; stall = 1;
    step();
    clear_inputs();
    e = expect_snap(8'h22, 16'd11, 1'b0, 1'b1);
    vectors++;
    if (snap !== e) begin miscompares++; $display("FAIL halt got %h exp %h", snap, e); end

    jump = 1; target = 8'h55; branch_taken = 1; offset = 8'h07; halt_req = 1;
    step();
    clear_inputs();
    vectors++;
    if (snap !== e) begin miscompares++; $display("FAIL halted_ignore got %h exp %h", snap, e); end

    start = 1; start_addr = 8'h00;
    step();
    clear_inputs();
    e = expect_snap(8'h00, 16'd0, 1'b1, 1'b0);
    vectors++;
    if (snap !== e) begin miscompares++; $display("FAIL restart got %h exp %h", snap, e); end
  endtask

  task automatic test_reset_mid_run();
    logic [34:0] e;
    jump = 1; target = 8'h37;
    step();
    clear_inputs();
    e = expect_snap(8'h37, 16'd1, 1'b1, 1'b0);
    vectors++;
    if (snap !== e) begin miscompares++; $display("FAIL jump_37 got %h exp %h", snap, e); end

    reset = 1; jump = 1; target = 8'h12;
    step();
    clear_inputs();
    e = expect_snap(8'h00, 16'd0, 1'b0, 1'b0);
    vectors++;
    if (snap !== e) begin miscompares++; $display("FAIL reset_mid_run got %h exp %h", snap, e); end

    reset = 1; start = 1; start_addr = 8'h10;
    step();
    clear_inputs();
    vectors++;
    if (snap !== e) begin miscompares++; $display("FAIL reset_with_start got %h exp %h", snap, e); end

    // Still IDLE: redirects and halt are ignored.
    jump = 1; target = 8'h44; halt_req = 1;
    step();
    clear_inputs();
    vectors++;
    if (snap !== e) begin miscompares++; $display("FAIL idle_ignore got %h exp %h", snap, e); end
  endtask

  task automatic test_saturation();
    start = 1; start_addr = 8'h00;
    step();
    clear_inputs();
    repeat (65534) @(posedge clk);
    #1;
    vectors++;
    if (ret_count !== 16'hFFFE) begin
      miscompares++; $display("FAIL cnt_fffe got %h exp %h", ret_count, 16'hFFFE);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      vectors++;
      if (ret_count !== 16'hFFFF) begin
        miscompares++; $display("FAIL cnt_sat_%0d got %h exp %h", i, ret_count, 16'hFFFF);
      end
    end
    // PC after 65537 increments from 0 is 65537 mod 256 = 1.
    vectors++;
    if (pc !== 8'h01) begin miscompares++; $display("FAIL sat_pc got %h exp %h", pc, 8'h01); end
  endtask

  initial begin
    clear_inputs();
    #2;
    test_reset();
    test_sequential();
    test_branch_wrap();
    test_priority();
    test_halt();
    test_reset_mid_run();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: PC_W, 8, program counter width; equals the instruction ROM address width.
REQ-002 Parameter: INST_W, 9, instruction width returned by the instruction ROM.
REQ-003 Parameter: CNT_W, 16, retired-instruction counter width.
REQ-004 Port: CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 Port: Reset  input  1  synchronous, active-high reset.
REQ-006 Port: Start  input  1  one-cycle pulse; begins execution at StartAddr.
REQ-007 Port: StartAddr  input  PC_W  first fetch address, sampled on Start.
REQ-008 Port: Stall  input  1  hold the PC this cycle.
REQ-009 Port: Jump  input  1  absolute redirect to Target.
REQ-010 Port: Target  input  PC_W  absolute jump destination.
REQ-011 Port: BranchTaken  input  1  relative redirect by Offset.
REQ-012 Port: Offset  input  PC_W  two's-complement branch displacement, applied relative to the current PC.
REQ-013 Port: HaltReq  input  1  stop fetching after the current instruction.
REQ-014 Port: Instruction  input  INST_W  combinational ROM data for the current PC.
REQ-015 Port: PC  output  PC_W  registered fetch address, drives the ROM Address input.
REQ-016 Port: InstOut  output  INST_W  Instruction passed to the decoder; zero when InstValid=0.
REQ-017 Port: InstValid  output  1  high only in RUN.
REQ-018 Port: Done  output  1  registered; high in HALTED.
REQ-019 Port: RetCount  output  CNT_W  count of instructions retired since the last Start.

Function
REQ-020 The FSM SHALL have three states: IDLE, RUN and HALTED.
REQ-021 IDLE->RUN on Start; PC<=StartAddr; RetCount<=0.
REQ-022 RUN->HALTED on HaltReq; the PC SHALL hold, Done SHALL assert the next cycle, and the halting instruction SHALL count as retired.
REQ-023 HALTED->RUN on Start, with the same loads as REQ-021; all other inputs SHALL be ignored in HALTED.
REQ-024 In IDLE, Stall, Jump, BranchTaken and HaltReq SHALL be ignored and the PC SHALL hold.
REQ-025 The next-PC priority in RUN SHALL be: HaltReq > Stall > Jump > BranchTaken > PC+1.
REQ-026 Jump: PC<=Target.
REQ-027 Branch: PC<=(PC+Offset) mod 2^PC_W; the sum SHALL wrap with no carry-out retained.
REQ-028 Increment: PC<=(PC+1) mod 2^PC_W; 255 SHALL wrap to 0 for PC_W=8.
REQ-029 Redirect latency: a new PC SHALL appear exactly one cycle after the Jump or BranchTaken cycle.
REQ-030 Stall in RUN: PC, RetCount and state SHALL hold; InstValid SHALL stay high and InstOut SHALL keep tracking Instruction.
REQ-031 RetCount SHALL increment in every RUN cycle without Stall, and SHALL saturate at 2^CNT_W-1.
REQ-032 InstOut SHALL be a combinational pass-through of Instruction when InstValid=1.
REQ-033 If Start is asserted in RUN, it SHALL be ignored.

Reset
REQ-034 On a Reset cycle the block SHALL set: state=IDLE, PC=0, RetCount=0, Done=0, InstValid=0, InstOut=0.
REQ-035 Reset SHALL take priority over every other input in every state, including mid-RUN and on the same cycle as Start.

Structure
REQ-036 A shared package SHALL hold the fetch_state_t enum (IDLE, RUN, HALTED) and the defaults for PC_W, INST_W and CNT_W.
REQ-037 A single sub-module, pc_next_logic, SHALL hold the combinational next-PC mux and adder; the FSM and registers SHALL live in fetch_unit.

Verification
REQ-038 Reset, then Start with StartAddr=0x10, then 3 free cycles -> PC sequence 0x10, 0x11, 0x12, 0x13; RetCount=3.
REQ-039 PC=0x05, BranchTaken with Offset=0xFE (-2) -> next PC=0x03; PC=0xFF, no redirect -> next PC=0x00.
REQ-040 Jump=1 and BranchTaken=1 in the same cycle, Target=0x40 -> next PC=0x40; Stall=1 with Jump=1 -> PC holds.
REQ-041 HaltReq at PC=0x22 -> Done=1 next cycle, PC stays 0x22, InstValid=0, InstOut=0; then Start with StartAddr=0 -> RUN, PC=0, RetCount=0.
REQ-042 Reset asserted mid-RUN at PC=0x37 -> next cycle IDLE, PC=0, RetCount=0; Start and Reset in the same cycle -> remains IDLE.
REQ-043 Force RetCount to 0xFFFE, then run 3 unstalled cycles -> RetCount holds at 0xFFFF.
